// File: rtl/ddr2_pkg.sv
`default_nettype none
// =============================================================================
// ddr2_pkg : shared command encodings, bank selects and init step enumeration
// Revision : 1.0
// =============================================================================
package ddr2_pkg;

    // {csbar, rasbar, casbar, webar}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PREA  = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    localparam logic [1:0] BA_MR   = 2'b00;
    localparam logic [1:0] BA_EMR1 = 2'b01;
    localparam logic [1:0] BA_EMR2 = 2'b10;
    localparam logic [1:0] BA_EMR3 = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CKE_LOW    = 4'd1,
        ST_XPR        = 4'd2,
        ST_PREA1      = 4'd3,
        ST_EMRS2      = 4'd4,
        ST_EMRS3      = 4'd5,
        ST_EMRS1      = 4'd6,
        ST_MRS_DLLRST = 4'd7,
        ST_PREA2      = 4'd8,
        ST_REF1       = 4'd9,
        ST_REF2       = 4'd10,
        ST_MRS        = 4'd11,
        ST_EMRS1_OCD  = 4'd12,
        ST_EMRS1_EXIT = 4'd13,
        ST_DLL_WAIT   = 4'd14,
        ST_DONE       = 4'd15
    } step_e;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr2_init_sequencer_if.sv
`default_nettype none
// =============================================================================
// ddr2_init_sequencer_if : start/status handshake and DDR2 command bus
// Revision : 1.0
// =============================================================================
interface ddr2_init_sequencer_if;
    logic        initddr;
    logic        ready;
    logic        busy;
    logic        cke;
    logic        csbar;
    logic        rasbar;
    logic        casbar;
    logic        webar;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        odt;
    logic [3:0]  step;

    modport master (
        input  initddr,
        output ready, busy, cke, csbar, rasbar, casbar, webar, ba, a, odt, step
    );

    modport slave (
        output initddr,
        input  ready, busy, cke, csbar, rasbar, casbar, webar, ba, a, odt, step
    );
endinterface
`default_nettype wire

// File: rtl/ddr2_delay_cnt.sv
`default_nettype none
// =============================================================================
// ddr2_delay_cnt : loadable saturating down-counter with zero flag
// Revision : 1.0
// =============================================================================
module ddr2_delay_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/ddr2_init_sequencer.sv
`default_nettype none
// =============================================================================
// ddr2_init_sequencer : DDR2 power-up init command sequencer, owns bus until ready
// Revision : 1.0
// =============================================================================
module ddr2_init_sequencer
    import ddr2_pkg::*;
#(
    parameter int          T_CKE    = 200,
    parameter int          T_XPR    = 200,
    parameter int          T_RP     = 8,
    parameter int          T_MRD    = 2,
    parameter int          T_RFC    = 53,
    parameter int          T_DLL    = 200,
    parameter logic [12:0] MR_VAL   = 13'h0642,
    parameter logic [12:0] EMR1_VAL = 13'h0004
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr2_init_sequencer_if.master bus
);
    localparam int CNT_MAX = max_of(max_of(max_of(T_CKE, T_XPR), max_of(T_DLL, T_RFC)),
                                    max_of(T_RP, T_MRD));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    step_e       r_state;
    logic        r_req;
    logic        r_cke;
    logic        r_busy;
    logic        r_ready;
    logic [3:0]  r_cmd;
    logic [1:0]  r_ba;
    logic [12:0] r_a;

    logic             w_gap_zero;
    logic             w_dll_zero;
    logic             w_gap_load;
    logic             w_dll_load;
    logic             w_fire;
    logic [CNT_W-1:0] w_gap_val;
    step_e            w_next;
    logic [3:0]       w_cmd;
    logic [1:0]       w_ba;
    logic [12:0]      w_a;
    int               w_gap;

    ddr2_delay_cnt #(.WIDTH(CNT_W)) u_gap_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_gap_load),
        .i_value (w_gap_val),
        .o_zero  (w_gap_zero)
    );

    ddr2_delay_cnt #(.WIDTH(CNT_W)) u_dll_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_dll_load),
        .i_value (CNT_W'(T_DLL - 1)),
        .o_zero  (w_dll_zero)
    );

    // r_state names the last command issued; w_next is the one waiting on the gap timer.
    always_comb begin
        w_next = step_e'(4'(r_state) + 4'd1);
        w_fire = w_gap_zero && (r_state >= ST_XPR) && (r_state <= ST_EMRS1_OCD);
        w_cmd  = CMD_NOP;
        w_ba   = BA_MR;
        w_a    = '0;
        w_gap  = 1;
        case (w_next)
            ST_PREA1, ST_PREA2: begin w_cmd = CMD_PREA; w_a = 13'h0400; w_gap = T_RP; end
            ST_EMRS2:      begin w_cmd = CMD_MRS; w_ba = BA_EMR2; w_gap = T_MRD; end
            ST_EMRS3:      begin w_cmd = CMD_MRS; w_ba = BA_EMR3; w_gap = T_MRD; end
            ST_EMRS1:      begin w_cmd = CMD_MRS; w_ba = BA_EMR1; w_a = EMR1_VAL; w_gap = T_MRD; end
            ST_MRS_DLLRST: begin w_cmd = CMD_MRS; w_a = MR_VAL | 13'h0100; w_gap = T_MRD; end
            ST_REF1, ST_REF2: begin w_cmd = CMD_REF; w_gap = T_RFC; end
            ST_MRS:        begin w_cmd = CMD_MRS; w_a = MR_VAL; w_gap = T_MRD; end
            ST_EMRS1_OCD:  begin w_cmd = CMD_MRS; w_ba = BA_EMR1; w_a = EMR1_VAL | 13'h0380; w_gap = T_MRD; end
            ST_EMRS1_EXIT: begin w_cmd = CMD_MRS; w_ba = BA_EMR1; w_a = EMR1_VAL; end
            default:       begin end
        endcase
        w_gap_load = w_fire || (r_state == ST_IDLE && r_req) || (r_state == ST_CKE_LOW && w_gap_zero);
        if (r_state == ST_IDLE) begin
            w_gap_val = CNT_W'(T_CKE - 1);
        end else if (r_state == ST_CKE_LOW) begin
            w_gap_val = CNT_W'(T_XPR - 1);
        end else begin
            w_gap_val = CNT_W'(w_gap - 1);
        end
        w_dll_load = w_fire && (w_next == ST_MRS_DLLRST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_cke   <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_cmd   <= CMD_DESEL;
            r_ba    <= '0;
            r_a     <= '0;
        end else begin
            r_cmd <= r_cke ? CMD_NOP : CMD_DESEL;
            case (r_state)
                ST_IDLE: begin
                    r_req <= bus.initddr;
                    if (r_req) begin
                        r_req   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CKE_LOW;
                    end
                end
                ST_CKE_LOW: begin
                    if (w_gap_zero) begin
                        r_cke   <= 1'b1;
                        r_cmd   <= CMD_NOP;
                        r_state <= ST_XPR;
                    end
                end
                ST_EMRS1_EXIT, ST_DLL_WAIT: begin
                    if (w_dll_zero) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DLL_WAIT;
                    end
                end
                ST_DONE: begin end
                default: begin
                    if (w_fire) begin
                        r_cmd   <= w_cmd;
                        r_ba    <= w_ba;
                        r_a     <= w_a;
                        r_state <= w_next;
                    end
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.cke    = r_cke;
    assign {bus.csbar, bus.rasbar, bus.casbar, bus.webar} = r_cmd;
    assign bus.ba     = r_ba;
    assign bus.a      = r_a;
    assign bus.odt    = 1'b0;
    assign bus.step   = r_state;
endmodule
`default_nettype wire
